// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0]  FUNC7_MULDIV = 7'b0000001;
  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } muldiv_state_e;

endpackage

// File: rtl/restoring_divider_step.sv
// One combinational step of unsigned restoring division: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module restoring_divider_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dividend_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_q_bit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // The partial remainder is always below the divisor, so W+1 bits hold the shift and
  // the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_dividend_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[W];
  assign o_rem   = o_q_bit ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// M-extension multiply/divide unit: single-cycle or shift-add multiply, restoring divide,
// result returned over a valid/ready handshake with a stall to the hazard unit.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned MUL_MODE = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2:0]      i_func_3,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMin = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   r_state, w_state_nxt;
  muldiv_op_e      r_op, w_op_nxt, w_op;
  logic            r_neg_a, r_neg_b, w_neg_a_nxt, w_neg_b_nxt;
  logic [XLEN-1:0] r_hi, r_lo, r_b, w_hi_nxt, w_lo_nxt, w_b_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;

  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf;
  logic [2*XLEN-1:0] w_full_prod;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_hi_n, w_mul_lo_n;
  logic [XLEN-1:0]   w_div_rem, w_div_lo_n;
  logic              w_div_q;
  logic [XLEN-1:0]   w_mul_final, w_div_final;
  logic              w_last;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                               input logic neg, input logic hi);
    logic [2*XLEN-1:0] prod;
    prod = neg ? (2*XLEN)'(0) - mag : mag;
    return hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  endfunction

  // Operand decode at accept time.
  assign w_op       = muldiv_op_e'(i_func_3);
  assign w_a_signed = w_op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  assign w_b_signed = w_op inside {OpMulh, OpDiv, OpRem};
  assign w_a_neg    = w_a_signed & i_operand_a[XLEN-1];
  assign w_b_neg    = w_b_signed & i_operand_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? XLEN'(0) - i_operand_a : i_operand_a;
  assign w_b_mag    = w_b_neg ? XLEN'(0) - i_operand_b : i_operand_b;
  assign w_div_zero = (i_operand_b == '0);
  assign w_div_ovf  = w_b_signed & (i_operand_a == XMin) & (i_operand_b == '1);
  assign w_full_prod = (2*XLEN)'(w_a_mag) * (2*XLEN)'(w_b_mag);

  // Shift-add multiply step: {r_hi, r_lo} is the running product, r_lo the multiplier.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi_n = w_mul_sum[XLEN:1];
  assign w_mul_lo_n = {w_mul_sum[0], r_lo[XLEN-1:1]};

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  restoring_divider_step #(
    .W(XLEN)
  ) u_div_step (
    .i_rem          (r_hi),
    .i_dividend_bit (r_lo[XLEN-1]),
    .i_divisor      (r_b),
    .o_rem          (w_div_rem),
    .o_q_bit        (w_div_q)
  );
  assign w_div_lo_n = {r_lo[XLEN-2:0], w_div_q};

  assign w_mul_final = mul_pick({w_mul_hi_n, w_mul_lo_n}, r_neg_a ^ r_neg_b, r_op != OpMul);
  assign w_div_final = r_op[1] ? (r_neg_a ? XLEN'(0) - w_div_rem : w_div_rem)
                               : ((r_neg_a ^ r_neg_b) ? XLEN'(0) - w_div_lo_n : w_div_lo_n);
  assign w_last      = (r_cnt == CntW'(XLEN-1));

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_neg_a_nxt  = r_neg_a;
    w_neg_b_nxt  = r_neg_b;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_b_nxt      = r_b;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid && !i_flush) begin
          w_op_nxt    = w_op;
          w_neg_a_nxt = w_a_neg;
          w_neg_b_nxt = w_b_neg;
          w_cnt_nxt   = '0;
          w_hi_nxt    = '0;
          w_lo_nxt    = w_a_mag;
          w_b_nxt     = w_b_mag;
          if (i_func_3[2]) begin
            if (w_div_zero) begin
              w_result_nxt = i_func_3[1] ? i_operand_a : '1;
              w_state_nxt  = StDone;
            end else if (w_div_ovf) begin
              w_result_nxt = i_func_3[1] ? '0 : XMin;
              w_state_nxt  = StDone;
            end else begin
              w_state_nxt = StDiv;
            end
          end else if (MUL_MODE == 0) begin
            w_result_nxt = mul_pick(w_full_prod, w_a_neg ^ w_b_neg, w_op != OpMul);
            w_state_nxt  = StDone;
          end else begin
            w_state_nxt = StMul;
          end
        end
      end
      StMul: begin
        w_hi_nxt  = w_mul_hi_n;
        w_lo_nxt  = w_mul_lo_n;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_last) begin
          w_result_nxt = w_mul_final;
          w_state_nxt  = StDone;
        end
      end
      StDiv: begin
        w_hi_nxt  = w_div_rem;
        w_lo_nxt  = w_div_lo_n;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_last) begin
          w_result_nxt = w_div_final;
          w_state_nxt  = StDone;
        end
      end
      StDone: begin
        if (i_out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Flush wins everywhere and leaves the held result untouched.
    if (i_flush) begin
      w_state_nxt  = StIdle;
      w_cnt_nxt    = '0;
      w_result_nxt = r_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_op     <= OpMul;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_neg_a  <= w_neg_a_nxt;
      r_neg_b  <= w_neg_b_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_b      <= w_b_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_result    = r_result;
  // Stall covers the accept cycle and every iteration, never the result cycle.
  assign o_stall     = ((r_state == StIdle) & i_in_valid) | (r_state == StMul) |
                       (r_state == StDiv);

endmodule
